// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle logic/arith ops; iterative MUL/DIV only when ALU_EXEC_MULDIV_EN is defined.
// Latency: done one cycle after the accepting edge, or WIDTH+1 cycles for MUL/DIV.
// Backpressure: start is accepted only when busy=0 (IDLE or DONE); it is ignored while iterating.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             dbz,
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic [WIDTH-1:0] op_res;
    logic             op_dbz, op_ill;

`ifdef ALU_EXEC_MULDIV_EN
    localparam int CW = $clog2(WIDTH) + 1;

    logic             op_mul, op_div;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] acc_a, acc_b, acc_r;
    logic [WIDTH-1:0] acc_a_nxt, acc_r_nxt, step_res;
    logic [WIDTH:0]   shifted, diff;

    assign last = (cnt == CW'(WIDTH - 1));
`endif

    always_comb begin
        op_res = '0;
        op_dbz = 1'b0;
        op_ill = 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
        op_mul = 1'b0;
        op_div = 1'b0;
`endif
        case (alu_ctl)
            4'b0000: op_res = a & b;
            4'b0001: op_res = a | b;
            4'b0010: op_res = a + b;
            4'b0110: op_res = a - b;
            4'b0011: op_res = ~(a | b);
            4'b0100: op_res = a ^ b;
            4'b0111: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_EXEC_MULDIV_EN
            4'b1010: op_mul = 1'b1;
            4'b1111: begin
                if (b == '0) begin
                    op_res = '1;
                    op_dbz = 1'b1;
                end else begin
                    op_div = 1'b1;
                end
            end
`endif
            default: op_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                done      = (state == DONE);
                accept    = start;
                state_nxt = start ? DONE : IDLE;
`ifdef ALU_EXEC_MULDIV_EN
                if (start && op_mul) state_nxt = MUL;
                if (start && op_div) state_nxt = DIV;
`endif
            end
`ifdef ALU_EXEC_MULDIV_EN
            MUL, DIV: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU_EXEC_MULDIV_EN
    // MUL: acc_a=multiplicand, acc_b=multiplier, acc_r=product.
    // DIV: acc_a=dividend shifting out / quotient shifting in, acc_b=divisor, acc_r=remainder.
    always_comb begin
        shifted = {acc_r, acc_a[WIDTH-1]};
        diff    = shifted - {1'b0, acc_b};
        if (state == MUL) begin
            acc_a_nxt = acc_a << 1;
            acc_r_nxt = acc_b[0] ? acc_r + acc_a : acc_r;
            step_res  = acc_r_nxt;
        end else begin
            acc_a_nxt = {acc_a[WIDTH-2:0], ~diff[WIDTH]};
            acc_r_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            step_res  = acc_a_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            dbz     <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
            cnt     <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
            acc_r   <= '0;
`endif
        end else begin
`ifdef ALU_EXEC_MULDIV_EN
            if (busy) begin
                acc_a <= acc_a_nxt;
                acc_r <= acc_r_nxt;
                if (state == MUL) acc_b <= acc_b >> 1;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    result  <= step_res;
                    zero    <= (step_res == '0);
                    dbz     <= 1'b0;
                    illegal <= 1'b0;
                end
            end
            // A multi-cycle op leaves the previous result visible until its own done.
            if (accept && (op_mul || op_div)) begin
                acc_a <= a;
                acc_b <= b;
                acc_r <= '0;
                cnt   <= '0;
            end else
`endif
            if (accept) begin
                result  <= op_res;
                zero    <= (op_res == '0);
                dbz     <= op_dbz;
                illegal <= op_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec with an abstract reference model checked every cycle.
module tb_alu_exec;

    localparam int W = 32;
`ifdef ALU_EXEC_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int LAT_MD = MD ? W + 1 : 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   alu_ctl = 4'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, dbz, illegal;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    alu_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctl(alu_ctl),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .zero(zero), .dbz(dbz), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the operation table.
    function automatic void model_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] r, output logic d, output logic i,
                                     output logic multi);
        r = '0; d = 1'b0; i = 1'b0; multi = 1'b0;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0011: r = ~(x | y);
            4'b0100: r = x ^ y;
            4'b0111: r = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
            4'b1010: if (MD) begin multi = 1'b1; r = x * y; end else i = 1'b1;
            4'b1111: begin
                if (!MD) i = 1'b1;
                else if (y == '0) begin r = '1; d = 1'b1; end
                else begin multi = 1'b1; r = x / y; end
            end
            default: i = 1'b1;
        endcase
    endfunction

    logic         m_busy = 0, m_done = 0, m_zero = 0, m_dbz = 0, m_ill = 0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] p_res = '0;
    logic         p_dbz = 0, p_ill = 0;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] r;
        logic d, i, multi;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_zero = 0; m_dbz = 0; m_ill = 0; m_res = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_res = p_res; m_zero = (p_res == '0); m_dbz = p_dbz; m_ill = p_ill;
            end
        end else if (start) begin
            model_op(alu_ctl, a, b, r, d, i, multi);
            p_res = r; p_dbz = d; p_ill = i;
            if (multi) begin
                m_left = W; m_busy = 1; m_done = 0;
            end else begin
                m_done = 1; m_res = r; m_zero = (r == '0); m_dbz = d; m_ill = i;
            end
        end else begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("result", result, m_res);
            chk("zero", zero, m_zero);
            chk("dbz", dbz, m_dbz);
            chk("illegal", illegal, m_ill);
        end
    end

    // Called at a negedge; returns at the negedge where done is high.
    task automatic do_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int exp_lat, input bit noise);
        int cycles;
        start = 1'b1; alu_ctl = c; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 100) begin
            if (noise) begin
                start = (cycles % 3 == 0);
                alu_ctl = 4'b0010;
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk("latency", cycles, exp_lat);
    endtask

    task automatic op_lit(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_r, input string name);
        @(negedge clk);
        do_op(c, x, y, 1, 1'b0);
        chk(name, result, exp_r);
    endtask

    initial begin
        int seen;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 1'b0);
        chk("add_ovf", result, 32'h8000_0000);
        chk("add_zero", zero, 0);
        op_lit(4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, "slt_neg");
        op_lit(4'b0110, 32'h5, 32'h5, 32'h0, "sub_eq");
        chk("sub_zero", zero, 1);
        op_lit(4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, "slt_pos");
        op_lit(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, "slt_min");
        op_lit(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, "and");
        op_lit(4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, "or");
        op_lit(4'b0011, 32'h0F0F_0F0F, 32'hF0F0_0000, 32'h0000_F0F0, "nor");
        op_lit(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, "xor");
        op_lit(4'b0110, 32'h0, 32'h1, 32'hFFFF_FFFF, "sub_wrap");

        @(negedge clk);
        do_op(4'b1010, 32'h0001_2345, 32'h100, LAT_MD, 1'b1);
`ifdef ALU_EXEC_MULDIV_EN
        chk("mul", result, 32'h0123_4500);
`else
        chk("mul_illegal", illegal, 1);
`endif
        @(negedge clk);
        do_op(4'b1111, 32'd100, 32'd7, LAT_MD, 1'b0);
`ifdef ALU_EXEC_MULDIV_EN
        chk("div", result, 32'd14);
`else
        chk("div_illegal", illegal, 1);
`endif
        do_op(4'b1111, 32'd5, 32'd0, 1, 1'b0);
`ifdef ALU_EXEC_MULDIV_EN
        chk("dbz_result", result, 32'hFFFF_FFFF);
        chk("dbz_flag", dbz, 1);
`else
        chk("dbz_flag_off", dbz, 0);
`endif
        do_op(4'b1111, 32'hFFFF_FFFF, 32'd1, LAT_MD, 1'b0);
        do_op(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MD, 1'b0);
        do_op(4'b1111, 32'd7, 32'd100, LAT_MD, 1'b0);

        @(negedge clk);
        do_op(4'b1001, 32'h1234, 32'h5678, 1, 1'b0);
        chk("ill_flag", illegal, 1);
        chk("ill_result", result, 0);
        do_op(4'b0010, 32'd1, 32'd1, 1, 1'b0);
        chk("b2b_add", result, 32'd2);
        chk("b2b_ill_clr", illegal, 0);

        @(negedge clk);
        start = 1'b1; alu_ctl = 4'b1010; a = 32'h0001_2345; b = 32'h100;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_flags", {zero, dbz, illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        do_op(4'b0010, 32'd3, 32'd4, 1, 1'b0);
        chk("post_reset_add", result, 32'd7);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
